// File: rtl/p6_pkg.sv
// p6_pkg: shared P6 pipeline types and fetch-address constants.
package p6_pkg;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_IM_BASE = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_IM_END = 32'h0000_6FFF;
endpackage

// File: rtl/f_pc_ctrl.sv
// f_pc_ctrl: F-stage PC sequencer with delay-slot-ordered redirects and IM handshake.
// Define F_PC_ADDR_CHECK_EN to turn illegal fetch addresses into F_exc_adel nops.
module f_pc_ctrl
  import p6_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] IM_BASE = DEFAULT_IM_BASE,
  parameter logic [31:0] IM_END = DEFAULT_IM_END
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_take,
  input  logic [31:0] br_target,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ready,
  input  logic [31:0] im_rdata,
  output logic [31:0] F_PC,
  output logic [31:0] F_instr,
  output logic        F_valid,
  output logic        F_exc_adel
);
  state_t state;
  logic [31:0] pc, hold, pend;
  logic pend_v, fetch, held, bad, accept;
`ifdef F_PC_ADDR_CHECK_EN
  assign bad = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_END);
`else
  logic unused_cfg;
  assign unused_cfg = ^{IM_BASE, IM_END};
  assign bad = 1'b0;
`endif
  assign fetch = state == S_FETCH;
  assign held = state == S_HOLD;
  assign im_req = fetch & ~bad;
  assign im_addr = pc;
  assign F_PC = pc;
  assign F_valid = held | (fetch & (bad | im_ready));
  assign F_instr = held ? hold : (fetch & im_ready & ~bad) ? im_rdata : NOP_INSTR;
  assign F_exc_adel = (fetch | held) & bad;
  assign accept = F_valid & ~stall;
  // A redirect seen while the delay slot is still in F is parked until that slot is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      pc <= RESET_PC;
      hold <= '0;
      pend <= '0;
      pend_v <= 1'b0;
    end else begin
      state <= (state == S_IDLE) ? S_FETCH : (F_valid & stall) ? S_HOLD : S_FETCH;
      if (fetch & F_valid & stall) hold <= F_instr;
      if (accept) begin
        pc <= br_take ? br_target : pend_v ? pend : pc + 32'd4;
        pend_v <= 1'b0;
      end else if (br_take) begin
        pend <= br_target;
        pend_v <= 1'b1;
      end
    end
  end
endmodule
